// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between icache (0) and dcache (1).
// Define MEM_ARB_PERF_EN to add saturating grant/stall performance counters.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_gnt0,
  output logic [31:0]     perf_gnt1,
  output logic [31:0]     perf_stall1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last;
  logic       sel;
  logic       win;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      sel       <= 1'b0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            sel       <= win;
            gnt       <= {win, ~win};
            mem_addr  <= win ? addr[2*AW-1:AW] : addr[AW-1:0];
            mem_wdata <= win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
            mem_we    <= we[win];
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= 4'd0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          // mem_rdata is only valid in the final busy cycle; writes return zero.
          if (cnt == LAST_CNT) begin
            rdata  <= mem_we ? '0 : mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            done   <= gnt;
            state  <= DONE;
          end
        end
        DONE: begin
          last  <= sel;
          done  <= 2'b00;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt    <= 2'b00;
          done   <= 2'b00;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_gnt0   <= 32'd0;
      perf_gnt1   <= 32'd0;
      perf_stall1 <= 32'd0;
    end else begin
      if (state == DONE && !sel && perf_gnt0 != 32'hFFFF_FFFF)
        perf_gnt0 <= perf_gnt0 + 32'd1;
      if (state == DONE && sel && perf_gnt1 != 32'hFFFF_FFFF)
        perf_gnt1 <= perf_gnt1 + 32'd1;
      if (req[1] && !gnt[1] && perf_stall1 != 32'hFFFF_FFFF)
        perf_stall1 <= perf_stall1 + 32'd1;
    end
  end
`endif

endmodule
